// File: rtl/watch_config_ctrl.sv
// Push-button front end for the watch counter: debounces four raw keys and runs the
// RUN/SET mode FSM that drives enable, clear, digit select, increment and blink mask.
module watch_config_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 5_000_000,
    parameter int unsigned BLINK_HALF      = 12_500_000,
    parameter int unsigned TIMEOUT_CYCLES  = 1_500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode_n,
    input  logic       key_next_n,
    input  logic       key_inc_n,
    input  logic       key_clr_n,
    output logic       enable,
    output logic       clr,
    output logic [2:0] config_digit,
    output logic       config_add,
    output logic       set_mode,
    output logic [5:0] blank_mask
);

    localparam int unsigned NKEY   = 4;
    localparam int unsigned K_MODE = 0;
    localparam int unsigned K_NEXT = 1;
    localparam int unsigned K_INC  = 2;
    localparam int unsigned K_CLR  = 3;

    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RPW = (REP_MAX > 1)         ? $clog2(REP_MAX)         : 1;
    localparam int unsigned BLW = (BLINK_HALF > 1)      ? $clog2(BLINK_HALF)      : 1;
    localparam int unsigned TOW = (TIMEOUT_CYCLES > 1)  ? $clog2(TIMEOUT_CYCLES)  : 1;

    localparam logic [0:0] ST_RUN = 1'b0;
    localparam logic [0:0] ST_SET = 1'b1;

    // Key inputs: 2-FF synchroniser, debounce counter, registered press pulse
    logic [NKEY-1:0] raw_n;
    logic [NKEY-1:0] sync1;
    logic [NKEY-1:0] sync2;
    logic [NKEY-1:0] deb;
    logic [NKEY-1:0] deb_d;
    logic [NKEY-1:0] press;
    logic [DBW-1:0]  db_cnt [NKEY];

    assign raw_n = {key_clr_n, key_inc_n, key_next_n, key_mode_n};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            deb_d <= '1;
            press <= '0;
            for (int i = 0; i < NKEY; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw_n;
            sync2 <= sync1;
            deb_d <= deb;
            press <= deb_d & ~deb;
            for (int i = 0; i < NKEY; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    // Mode FSM state and registered outputs
    logic [0:0]     state,       state_nxt;
    logic [2:0]     digit_nxt;
    logic           phase,       phase_nxt;
    logic [BLW-1:0] blink_cnt,   blink_cnt_nxt;
    logic [TOW-1:0] to_cnt,      to_cnt_nxt;
    logic           rep_active,  rep_active_nxt;
    logic           rep_first,   rep_first_nxt;
    logic [RPW-1:0] rep_cnt,     rep_cnt_nxt;
    logic           rep_fire;
    logic           enable_nxt;
    logic           clr_nxt;
    logic           add_nxt;
    logic           set_mode_nxt;
    logic [5:0]     blank_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_RUN;
            config_digit <= '0;
            phase        <= 1'b0;
            blink_cnt    <= '0;
            to_cnt       <= '0;
            rep_active   <= 1'b0;
            rep_first    <= 1'b0;
            rep_cnt      <= '0;
            enable       <= 1'b0;
            clr          <= 1'b0;
            config_add   <= 1'b0;
            set_mode     <= 1'b0;
            blank_mask   <= '0;
        end else begin
            state        <= state_nxt;
            config_digit <= digit_nxt;
            phase        <= phase_nxt;
            blink_cnt    <= blink_cnt_nxt;
            to_cnt       <= to_cnt_nxt;
            rep_active   <= rep_active_nxt;
            rep_first    <= rep_first_nxt;
            rep_cnt      <= rep_cnt_nxt;
            enable       <= enable_nxt;
            clr          <= clr_nxt;
            config_add   <= add_nxt;
            set_mode     <= set_mode_nxt;
            blank_mask   <= blank_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        digit_nxt      = config_digit;
        phase_nxt      = phase;
        blink_cnt_nxt  = blink_cnt;
        to_cnt_nxt     = to_cnt;
        rep_active_nxt = rep_active;
        rep_first_nxt  = rep_first;
        rep_cnt_nxt    = rep_cnt;
        rep_fire       = 1'b0;
        add_nxt        = 1'b0;
        clr_nxt        = press[K_CLR];

        case (state)
            ST_RUN: begin
                rep_active_nxt = 1'b0;
                if (press[K_MODE]) begin
                    state_nxt     = ST_SET;
                    digit_nxt     = 3'd0;
                    phase_nxt     = 1'b0;
                    blink_cnt_nxt = '0;
                    to_cnt_nxt    = '0;
                end
            end
            default: begin
                if (blink_cnt == BLW'(BLINK_HALF - 1)) begin
                    blink_cnt_nxt = '0;
                    phase_nxt     = ~phase;
                end else begin
                    blink_cnt_nxt = blink_cnt + BLW'(1);
                end
                to_cnt_nxt = to_cnt + TOW'(1);

                // Auto-repeat runs only while inc stays debounced-pressed
                if (rep_active && !deb[K_INC]) begin
                    if (rep_cnt == (rep_first ? RPW'(REPEAT_DELAY - 1) : RPW'(REPEAT_PERIOD - 1))) begin
                        rep_fire      = 1'b1;
                        rep_cnt_nxt   = '0;
                        rep_first_nxt = 1'b0;
                    end else begin
                        rep_cnt_nxt = rep_cnt + RPW'(1);
                    end
                end else begin
                    rep_active_nxt = 1'b0;
                end

                if (|press) to_cnt_nxt = '0;

                if (press[K_MODE]) begin
                    state_nxt      = ST_RUN;
                    digit_nxt      = 3'd0;
                    phase_nxt      = 1'b0;
                    rep_active_nxt = 1'b0;
                end else if (press[K_NEXT]) begin
                    digit_nxt = (config_digit == 3'd5) ? 3'd0 : config_digit + 3'd1;
                end else if (press[K_INC] || rep_fire) begin
                    add_nxt       = 1'b1;
                    phase_nxt     = 1'b0;
                    blink_cnt_nxt = '0;
                    to_cnt_nxt    = '0;
                    if (press[K_INC]) begin
                        rep_active_nxt = 1'b1;
                        rep_first_nxt  = 1'b1;
                        rep_cnt_nxt    = '0;
                    end
                end else if (to_cnt == TOW'(TIMEOUT_CYCLES - 1) && !press[K_CLR]) begin
                    state_nxt      = ST_RUN;
                    digit_nxt      = 3'd0;
                    phase_nxt      = 1'b0;
                    rep_active_nxt = 1'b0;
                end
            end
        endcase

        enable_nxt   = (state_nxt == ST_RUN);
        set_mode_nxt = (state_nxt == ST_SET);
        blank_nxt    = (state_nxt == ST_SET && phase_nxt) ? 6'(6'b000001 << digit_nxt) : 6'b000000;
    end

endmodule

// File: tb/tb_watch_config_ctrl.sv
// Directed scoreboard bench for watch_config_ctrl with short debounce/repeat/blink/timeout.
module tb_watch_config_ctrl;

    localparam int unsigned DEB = 4;
    localparam int unsigned RD  = 20;
    localparam int unsigned RP  = 5;
    localparam int unsigned BH  = 8;
    localparam int unsigned TO  = 100;

    localparam logic [3:0] M_MODE = 4'b0001;
    localparam logic [3:0] M_NEXT = 4'b0010;
    localparam logic [3:0] M_INC  = 4'b0100;
    localparam logic [3:0] M_CLR  = 4'b1000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_mode_n = 1'b1;
    logic       key_next_n = 1'b1;
    logic       key_inc_n  = 1'b1;
    logic       key_clr_n  = 1'b1;
    logic       enable;
    logic       clr;
    logic [2:0] config_digit;
    logic       config_add;
    logic       set_mode;
    logic [5:0] blank_mask;

    always #5 clk = ~clk;

    watch_config_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .BLINK_HALF     (BH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_mode_n  (key_mode_n),
        .key_next_n  (key_next_n),
        .key_inc_n   (key_inc_n),
        .key_clr_n   (key_clr_n),
        .enable      (enable),
        .clr         (clr),
        .config_digit(config_digit),
        .config_add  (config_add),
        .set_mode    (set_mode),
        .blank_mask  (blank_mask)
    );

    string       tag_q[$];
    logic [31:0] val_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    int          overlap = 0;
    int          bad_dig = 0;

    function automatic void expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endfunction

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_total++;
        if (val_q.size() == 0) begin
            $display("FAIL scoreboard_empty: observed %0h with nothing expected", obs);
        end else begin
            t = tag_q.pop_front();
            e = val_q.pop_front();
            assert (obs === e) begin
                n_pass++;
            end else begin
                $error("FAIL %s: observed %0h expected %0h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (config_add && enable) overlap++;
        if (config_digit > 3'd5) bad_dig++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input logic [3:0] m);
        key_mode_n = ~m[0];
        key_next_n = ~m[1];
        key_inc_n  = ~m[2];
        key_clr_n  = ~m[3];
    endtask

    task automatic press(input logic [3:0] m);
        drive(m);
        ticks(6);
        drive(4'b0000);
        ticks(8);
    endtask

    task automatic watch(input int n, output int adds, output int clrs, output int set_hi,
                         output logic [2:0] dig);
        adds = 0; clrs = 0; set_hi = 0; dig = 3'd7;
        for (int i = 0; i < n; i++) begin
            tick();
            if (config_add) begin adds++; dig = config_digit; end
            if (clr) clrs++;
            if (set_mode) set_hi++;
        end
    endtask

    task automatic wait_set();
        int k;
        k = 0;
        while (!set_mode && k < 20) begin tick(); k++; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          adds, clrs, set_hi, first, k;
        logic [2:0]  dig;
        int          offs[$];

        // Reset state
        drive(4'b0000);
        ticks(3);
        expect_val("reset_outputs", 32'd0);
        check(32'({enable, clr, config_digit, config_add, set_mode, blank_mask}));
        @(negedge clk) rst = 1'b1;
        tick();
        expect_val("enable_after_reset", 32'd1);
        check(32'(enable));

        // Mode glitch of 3 cycles gives no event
        drive(M_MODE); ticks(3); drive(4'b0000);
        watch(15, adds, clrs, set_hi, dig);
        expect_val("mode_glitch_no_event", 32'd0);
        check(32'(set_hi));

        // Mode held 10 cycles: SET entered 7 edges after first low sample
        drive(M_MODE);
        first = -1;
        for (int e = 0; e < 25; e++) begin
            tick();
            if (e == 9) drive(4'b0000);
            if (set_mode && first < 0) first = e;
        end
        expect_val("mode_event_edge", 32'd7);
        check(32'(first));
        expect_val("set_state_outs", 32'b0_0_000_0_1);
        check(32'({enable, clr, config_digit, config_add, set_mode}));

        // Digit cycling with next presses
        for (int i = 0; i < 7; i++) begin
            expect_val("next_digit", 32'((i + 1) % 6));
            press(M_NEXT);
            check(32'(config_digit));
        end
        press(M_NEXT);
        press(M_NEXT);
        expect_val("digit_before_inc", 32'd3);
        check(32'(config_digit));

        // Inc glitch in SET gives no increment
        drive(M_INC); ticks(3); drive(4'b0000);
        watch(20, adds, clrs, set_hi, dig);
        expect_val("inc_glitch_no_add", 32'd0);
        check(32'(adds));

        // Single inc press
        drive(M_INC); ticks(6); drive(4'b0000);
        watch(30, adds, clrs, set_hi, dig);
        expect_val("inc_single_add", 32'd1);
        check(32'(adds));
        expect_val("inc_add_digit", 32'd3);
        check(32'(dig));

        // Auto-repeat: held inc, released 32 cycles after first pulse
        drive(M_INC);
        k = 0;
        while (!config_add && k < 20) begin tick(); k++; end
        expect_val("repeat_first_pulse", 32'd1);
        check(32'(config_add));
        for (int off = 1; off <= 70; off++) begin
            tick();
            if (off == 32) drive(4'b0000);
            if (config_add) offs.push_back(off);
        end
        expect_val("repeat_pulse_count", 32'd4);
        check(32'(offs.size()));
        for (int i = 0; i < 4; i++) begin
            expect_val("repeat_offset", 32'(RD + RP * i));
            check((i < offs.size()) ? 32'(offs[i]) : 32'hFFFF_FFFF);
        end

        // Simultaneous mode+next+clr in SET
        drive(M_MODE | M_NEXT | M_CLR); ticks(6); drive(4'b0000);
        watch(10, adds, clrs, set_hi, dig);
        expect_val("simul_clr_pulses", 32'd1);
        check(32'(clrs));
        expect_val("simul_no_add", 32'd0);
        check(32'(adds));
        expect_val("simul_run_state", 32'b1_000_0);
        check(32'({enable, config_digit, set_mode}));

        // Clear in RUN keeps RUN
        drive(M_CLR); ticks(6); drive(4'b0000);
        watch(10, adds, clrs, set_hi, dig);
        expect_val("run_clr_pulses", 32'd1);
        check(32'(clrs));
        expect_val("run_clr_stays_run", 32'd0);
        check(32'(set_hi));

        // Blink and timeout with no activity
        drive(M_MODE);
        wait_set();
        drive(4'b0000);
        expect_val("enter_set_for_timeout", 32'd1);
        check(32'(set_mode));
        for (int c = 1; c < int'(TO); c++) begin
            tick();
            expect_val("blink_mask", ((c / int'(BH)) % 2 == 1) ? 32'd1 : 32'd0);
            check(32'(blank_mask));
        end
        expect_val("still_set_before_timeout", 32'd1);
        check(32'(set_mode));
        tick();
        expect_val("timeout_to_run", 32'b1_0_000000);
        check(32'({enable, set_mode, blank_mask}));

        // Clear inside SET keeps SET and digit
        drive(M_MODE); wait_set(); drive(4'b0000); ticks(8);
        press(M_NEXT);
        drive(M_CLR); ticks(6); drive(4'b0000);
        watch(10, adds, clrs, set_hi, dig);
        expect_val("set_clr_pulses", 32'd1);
        check(32'(clrs));
        expect_val("set_clr_keeps_set", 32'd10);
        check(32'(set_hi));
        expect_val("set_clr_keeps_digit", 32'd1);
        check(32'(config_digit));

        // Reset while inc held in SET
        drive(M_INC); ticks(12);
        rst = 1'b0;
        #1;
        expect_val("reset_mid_set", 32'd0);
        check(32'({enable, clr, config_digit, config_add, set_mode, blank_mask}));
        ticks(3);
        expect_val("reset_held", 32'd0);
        check(32'({enable, clr, config_digit, config_add, set_mode, blank_mask}));
        @(negedge clk) rst = 1'b1;
        tick();
        expect_val("enable_after_mid_reset", 32'd1);
        check(32'(enable));
        watch(30, adds, clrs, set_hi, dig);
        expect_val("post_reset_no_add", 32'd0);
        check(32'(adds));
        expect_val("post_reset_run", 32'd0);
        check(32'(set_hi));
        drive(4'b0000);
        ticks(10);

        expect_val("add_enable_overlap", 32'd0);
        check(32'(overlap));
        expect_val("digit_range", 32'd0);
        check(32'(bad_dig));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/watch_config_ctrl.md
Name: watch_config_ctrl

Overview:
- Front-end controller for the digital watch counter. Takes four raw active-low push-buttons and produces the counter's control strobes: `enable`, `clr`, `config_digit`, `config_add`.
- Each button is synchronised and debounced. A RUN/SET mode FSM runs on top, with auto-repeat for increment and an inactivity timeout.
- Also produces a blink mask so the display stage can flash the digit being edited.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a key level change (20 ms at 50 MHz).
- REPEAT_DELAY, 25_000_000, cycles inc must be held in SET before the first auto-repeat.
- REPEAT_PERIOD, 5_000_000, cycles between subsequent auto-repeats.
- BLINK_HALF, 12_500_000, cycles per blink half-period.
- TIMEOUT_CYCLES, 1_500_000_000, idle cycles in SET before automatic return to RUN (30 s).

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-low reset
- key_mode_n  in  1  raw mode button, low = pressed, asynchronous
- key_next_n  in  1  raw next-digit button, low = pressed
- key_inc_n  in  1  raw increment button, low = pressed
- key_clr_n  in  1  raw clear button, low = pressed
- enable  out  1  counter run enable
- clr  out  1  one-cycle synchronous clear strobe
- config_digit  out  3  selected digit: 0 = s_unit … 5 = h_ten
- config_add  out  1  one-cycle increment strobe for the selected digit
- set_mode  out  1  high while in SET
- blank_mask  out  6  bit i high = blank display digit i this cycle

Behaviour:
- Reset (rst low, asynchronous):
  - FSM = RUN; all outputs 0: enable, clr, config_digit, config_add, set_mode, blank_mask.
  - All counters 0; debounced levels = released.
- Synchroniser: each key passes through a 2-FF synchroniser.
- Debounce, per key:
  - cnt increments while sync level ≠ debounced level; cnt clears to 0 whenever they are equal.
  - When cnt == DEBOUNCE_CYCLES-1 and the mismatch persists, debounced level <= sync level and cnt <= 0.
  - A released→pressed transition produces a registered one-cycle press pulse. Latency is DEBOUNCE_CYCLES+3 clk edges from the first edge that samples the key low.
  - Release produces no event. Glitches shorter than DEBOUNCE_CYCLES produce nothing.
  - A key held low across reset release yields exactly one press event.
- All outputs are registered.
- RUN state:
  - enable=1 (first rising edge after reset release onward); set_mode=0; blank_mask=0; config_add never asserted.
  - Mode press → SET: config_digit<=0, blink phase<=0, timeout cnt<=0, enable<=0 on the same edge.
  - Next and inc presses are ignored.
- SET state:
  - enable=0; set_mode=1.
  - Next press: config_digit <= (config_digit==5) ? 0 : config_digit+1.
  - Inc press: config_add=1 for exactly one cycle. Blink phase and blink counter reset, so the digit shows immediately.
  - Auto-repeat: while inc stays debounced-pressed, an extra config_add pulse fires REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles. Repeat stops on debounced release or on exit from SET.
  - Mode press → RUN: enable<=1, blank_mask<=0, config_digit<=0.
  - Timeout cnt clears on any press or repeat. When it reaches TIMEOUT_CYCLES-1 → RUN, same as a mode press.
  - blank_mask = blink_phase ? (6'b1 << config_digit) : 0. The phase toggles every BLINK_HALF cycles.
- Clear:
  - A clr press in any state gives clr=1 for exactly one cycle.
  - State and config_digit are unchanged. In SET, the timeout cnt is cleared.
- Priority for events pulsing in the same cycle: clr > mode > next > inc/repeat.
  - clr is still issued alongside any lower-priority action.
  - Of mode/next/inc, only the highest is acted on; lower ones are dropped, not queued.
- Invariants:
  - config_add and enable are never high in the same cycle.
  - config_add is at most one cycle wide.
  - config_digit ∈ 0..5 always.
- Reset mid-SET: immediate return to RUN; all strobes low; pending repeat/timeout discarded.

Test Plan:
- Test parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, BLINK_HALF=8, TIMEOUT_CYCLES=100.
- Debounce: key_inc_n low for 3 cycles, then high → no event. Hold mode low 10 cycles → one mode event exactly 7 edges after first low sample; set_mode=1, enable=0.
- Digit cycling: in SET, 7 next presses → config_digit sequence 1,2,3,4,5,0,1. Inc press at digit 3 → single config_add pulse with config_digit=3.
- Auto-repeat: hold inc 40 cycles past its press pulse in SET → config_add pulses at +0, +20, +25, +30, +35. Release → no further pulses.
- Timeout/blink: enter SET, no activity → blank_mask toggles between 0 and 6'b000001 every 8 cycles. After 100 idle cycles → set_mode=0, enable=1, blank_mask=0.
- Simultaneous events: mode, next and clr pulse in the same cycle while in SET → clr high one cycle, state becomes RUN, config_digit=0, next ignored.
- Reset mid-SET: assert rst while inc is held → all outputs 0 immediately. After release: RUN, enable=1, no config_add.
